// File: rtl/wb_retire_unit_if.sv
// Bundle and result signals of the writeback/retire stage. The pipeline side drives
// the master modport and the retire unit takes the slave modport.
interface wb_retire_unit_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    localparam int MW = DATA_W / 8;
    localparam int LW = 32 + 1 + MW + AW + DATA_W;
    localparam int FW = 1 + MW + AW + DATA_W;

    logic [5:0]              stall;
    logic [LANES-1:0]        in_valid;
    logic [LANES*LW-1:0]     in_bus;
    logic [LANES-1:0]        rf_we;
    logic [LANES*MW-1:0]     rf_wmask;
    logic [LANES*AW-1:0]     rf_waddr;
    logic [LANES*DATA_W-1:0] rf_wdata;
    logic [LANES*FW-1:0]     fwd_bus;
    logic                    trace_ready;
    logic                    trace_valid;
    logic [31:0]             debug_wb_pc;
    logic [MW-1:0]           debug_wb_rf_wen;
    logic [AW-1:0]           debug_wb_rf_wnum;
    logic [DATA_W-1:0]       debug_wb_rf_wdata;
    logic                    stall_req;

    modport master (
        output stall, in_valid, in_bus, trace_ready,
        input  rf_we, rf_wmask, rf_waddr, rf_wdata, fwd_bus, trace_valid,
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, stall_req
    );

    modport slave (
        input  stall, in_valid, in_bus, trace_ready,
        output rf_we, rf_wmask, rf_waddr, rf_wdata, fwd_bus, trace_valid,
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, stall_req
    );
endinterface

// File: rtl/wb_retire_unit.sv
// Multi-lane writeback stage: drives RF writes and ID forwarding from the captured bundle,
// merges same-address lanes youngest-wins, and serialises traced writes onto one debug port.
module wb_retire_unit #(
    parameter int LANES       = 2,
    parameter int DATA_W      = 32,
    parameter int AW          = 5,
    parameter int TRACE_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_retire_unit_if.slave bus
);
    localparam int MW = DATA_W / 8;
    localparam int LW = 32 + 1 + MW + AW + DATA_W;
    localparam int FW = 1 + MW + AW + DATA_W;
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]       pc;
        logic [MW-1:0]     mask;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } trace_t;

    logic [LANES-1:0]    r_valid;
    logic [LANES*LW-1:0] r_bus;
    logic                r_fresh;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    trace_t              r_mem [TRACE_DEPTH];

    logic [31:0]       w_pc     [LANES];
    logic [MW-1:0]     w_mask   [LANES];
    logic [AW-1:0]     w_addr   [LANES];
    logic [DATA_W-1:0] w_data   [LANES];
    logic [MW-1:0]     w_mmask  [LANES];
    logic [PW-1:0]     w_wr_idx [LANES];
    logic [LANES-1:0]  w_we;
    logic [LANES-1:0]  w_eff;
    logic [LANES-1:0]  w_push;
    logic [LANES-1:0]  w_rf_we;
    logic [CW-1:0]     w_push_cnt;
    logic [CW:0]       w_count_nxt;
    logic              w_tvalid;
    logic              w_pop;
    trace_t            w_head;

    // stall[4]=1 stops this stage; if downstream still moves (stall[5]=0) a bubble is loaded.
    // NOTE: state is updated with <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_bus   <= '0;
            r_fresh <= 1'b0;
        end else if (!bus.stall[4]) begin
            r_valid <= bus.in_valid;
            r_bus   <= bus.in_bus;
            r_fresh <= 1'b1;
        end else if (!bus.stall[5]) begin
            r_valid <= '0;
            r_fresh <= 1'b0;
        end else begin
            r_fresh <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_data[i] = r_bus[i*LW +: DATA_W];
            w_addr[i] = r_bus[i*LW + DATA_W +: AW];
            w_mask[i] = r_bus[i*LW + DATA_W + AW +: MW];
            w_we[i]   = r_bus[i*LW + DATA_W + AW + MW];
            w_pc[i]   = r_bus[i*LW + DATA_W + AW + MW + 1 +: 32];
            w_eff[i]  = r_fresh & r_valid[i] & w_we[i] & (|w_mask[i]);
            w_push[i] = w_eff[i] & (|w_addr[i]);
        end
    end

    // Younger lanes strip overlapping bytes from older lanes hitting the same register.
    // NOTE: each variable gets a default before the conditional updates, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_mmask[i] = w_mask[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (w_eff[i] && w_eff[j] && (w_addr[i] == w_addr[j]))
                    w_mmask[i] = w_mmask[i] & ~w_mask[j];
            end
            w_rf_we[i] = w_eff[i] & (|w_mmask[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bus.rf_we[i]                  = w_rf_we[i];
            bus.rf_wmask[i*MW +: MW]      = w_mmask[i];
            bus.rf_waddr[i*AW +: AW]      = w_addr[i];
            bus.rf_wdata[i*DATA_W +: DATA_W] = w_data[i];
            bus.fwd_bus[i*FW +: FW]       = {w_rf_we[i], w_mmask[i], w_addr[i], w_data[i]};
        end
    end

    // Pushing lanes take consecutive slots from wr_ptr in lane order.
    always_comb begin : push_slots
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_wr_idx[i] = r_wr_ptr + acc[PW-1:0];
            acc         = acc + CW'(w_push[i]);
        end
        w_push_cnt = acc;
    end

    assign w_tvalid    = (r_count != '0);
    assign w_pop       = bus.trace_ready & w_tvalid;
    assign w_count_nxt = {1'b0, r_count} + {1'b0, w_push_cnt} - (CW+1)'(w_pop);

    // NOTE: trace storage has no reset; entries are only observed behind the count, which is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_push[i])
                r_mem[w_wr_idx[i]] <= {w_pc[i], w_mask[i], w_addr[i], w_data[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (w_count_nxt <= (CW+1)'(TRACE_DEPTH));
            r_wr_ptr <= r_wr_ptr + w_push_cnt[PW-1:0];
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= w_count_nxt[CW-1:0];
        end
    end

    // Pop is deliberately ignored so the request never depends on the debug consumer.
    assign bus.stall_req = ({1'b0, r_count} + {1'b0, w_push_cnt}) > (CW+1)'(TRACE_DEPTH - LANES);

    assign w_head                = r_mem[r_rd_ptr];
    assign bus.trace_valid       = w_tvalid;
    assign bus.debug_wb_pc       = w_tvalid ? w_head.pc   : '0;
    assign bus.debug_wb_rf_wen   = w_tvalid ? w_head.mask : '0;
    assign bus.debug_wb_rf_wnum  = w_tvalid ? w_head.addr : '0;
    assign bus.debug_wb_rf_wdata = w_tvalid ? w_head.data : '0;
endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit: capture, merge, hold, bubble, r0, trace back-pressure and reset.
module tb_wb_retire_unit;
    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 8;
    localparam int MW     = DATA_W / 8;
    localparam int LW     = 32 + 1 + MW + AW + DATA_W;
    localparam int FW     = 1 + MW + AW + DATA_W;

    localparam logic [5:0] S_RUN    = 6'b000000;
    localparam logic [5:0] S_HOLD   = 6'b110000;
    localparam logic [5:0] S_BUBBLE = 6'b010000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    wb_retire_unit_if #(.LANES(LANES), .DATA_W(DATA_W), .AW(AW)) ifc ();

    wb_retire_unit #(
        .LANES(LANES), .DATA_W(DATA_W), .AW(AW), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic v, input logic [31:0] pc, input logic we,
                            input logic [3:0] m, input logic [4:0] a, input logic [31:0] d);
        ifc.in_valid[l]        = v;
        ifc.in_bus[l*LW +: LW] = {pc, we, m, a, d};
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [3:0] m,
                            input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, 64'(ifc.trace_valid), 64'd1);
        chk({tag, ".pc"},    64'(ifc.debug_wb_pc), 64'(pc));
        chk({tag, ".wen"},   64'(ifc.debug_wb_rf_wen), 64'(m));
        chk({tag, ".wnum"},  64'(ifc.debug_wb_rf_wnum), 64'(a));
        chk({tag, ".wdata"}, 64'(ifc.debug_wb_rf_wdata), 64'(d));
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        ifc.stall       = S_RUN;
        ifc.in_valid    = '0;
        ifc.in_bus      = '0;
        ifc.trace_ready = 1'b0;
        tick();
        tick();
        chk("rst.trace_valid", 64'(ifc.trace_valid), 64'd0);
        chk("rst.rf_we", 64'(ifc.rf_we), 64'd0);
        chk("rst.stall_req", 64'(ifc.stall_req), 64'd0);
        chk("rst.wen", 64'(ifc.debug_wb_rf_wen), 64'd0);
        rst_n = 1'b1;

        // Single lane-0 write to r3
        set_lane(0, 1'b1, 32'hBFC00000, 1'b1, 4'hF, 5'd3, 32'h12345678);
        set_lane(1, 1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        tick();
        chk("t2.rf_we", 64'(ifc.rf_we), 64'h1);
        chk("t2.rf_waddr0", 64'(ifc.rf_waddr[AW-1:0]), 64'd3);
        chk("t2.rf_wdata0", 64'(ifc.rf_wdata[DATA_W-1:0]), 64'h12345678);
        chk("t2.fwd0", 64'(ifc.fwd_bus[FW-1:0]), {22'd0, 1'b1, 4'hF, 5'd3, 32'h12345678});
        chk("t2.trace_early", 64'(ifc.trace_valid), 64'd0);
        ifc.in_valid = '0;
        tick();
        chk("t2.rf_we_after", 64'(ifc.rf_we), 64'h0);
        chk_head("t2.head", 32'hBFC00000, 4'hF, 5'd3, 32'h12345678);
        ifc.trace_ready = 1'b1;
        tick();
        chk("t2.drained", 64'(ifc.trace_valid), 64'd0);

        // Same-address merge, youngest wins
        set_lane(0, 1'b1, 32'h100, 1'b1, 4'hF, 5'd5, 32'h11111111);
        set_lane(1, 1'b1, 32'h104, 1'b1, 4'h3, 5'd5, 32'h00002222);
        tick();
        chk("t3.rf_we", 64'(ifc.rf_we), 64'h3);
        chk("t3.wmask0", 64'(ifc.rf_wmask[3:0]), 64'hC);
        chk("t3.wmask1", 64'(ifc.rf_wmask[7:4]), 64'h3);
        ifc.in_valid = '0;
        tick();
        chk_head("t3.e0", 32'h100, 4'hF, 5'd5, 32'h11111111);
        tick();
        chk_head("t3.e1", 32'h104, 4'h3, 5'd5, 32'h00002222);
        tick();
        chk("t3.drained", 64'(ifc.trace_valid), 64'd0);

        // Hold three cycles after capture
        set_lane(0, 1'b1, 32'h200, 1'b1, 4'hF, 5'd7, 32'hAAAA0007);
        set_lane(1, 1'b1, 32'h204, 1'b1, 4'hF, 5'd8, 32'hBBBB0008);
        tick();
        chk("t4.rf_we_cap", 64'(ifc.rf_we), 64'h3);
        ifc.stall = S_HOLD;
        tick();
        chk("t4.rf_we_h1", 64'(ifc.rf_we), 64'h0);
        chk_head("t4.e0", 32'h200, 4'hF, 5'd7, 32'hAAAA0007);
        tick();
        chk("t4.rf_we_h2", 64'(ifc.rf_we), 64'h0);
        chk_head("t4.e1", 32'h204, 4'hF, 5'd8, 32'hBBBB0008);
        tick();
        chk("t4.rf_we_h3", 64'(ifc.rf_we), 64'h0);
        chk("t4.no_retrace", 64'(ifc.trace_valid), 64'd0);
        ifc.stall    = S_RUN;
        ifc.in_valid = '0;
        tick();
        chk("t4.idle", 64'(ifc.trace_valid), 64'd0);

        // Bubble, then an r0 write
        set_lane(0, 1'b1, 32'h300, 1'b1, 4'hF, 5'd9, 32'h33333333);
        ifc.stall = S_BUBBLE;
        tick();
        chk("t6.bubble_we", 64'(ifc.rf_we), 64'h0);
        ifc.stall    = S_RUN;
        ifc.in_valid = '0;
        tick();
        chk("t6.bubble_trace", 64'(ifc.trace_valid), 64'd0);
        set_lane(0, 1'b1, 32'h304, 1'b1, 4'hF, 5'd0, 32'h0000DEAD);
        tick();
        chk("t6.r0_we", 64'(ifc.rf_we), 64'h1);
        ifc.in_valid = '0;
        tick();
        chk("t6.r0_trace", 64'(ifc.trace_valid), 64'd0);

        // Back-pressure: consumer stalled, dual writes every cycle
        ifc.trace_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 1'b1, 32'h400 + 32'(8*k), 1'b1, 4'hF, 5'(10 + 2*k), 32'hC0DE0000 + 32'(2*k));
            set_lane(1, 1'b1, 32'h404 + 32'(8*k), 1'b1, 4'hF, 5'(11 + 2*k), 32'hC0DE0001 + 32'(2*k));
            tick();
            chk($sformatf("t5.sreq_k%0d", k), 64'(ifc.stall_req), (k == 3) ? 64'd1 : 64'd0);
        end
        set_lane(0, 1'b1, 32'h420, 1'b1, 4'hF, 5'd18, 32'hC0DE0008);
        set_lane(1, 1'b1, 32'h424, 1'b1, 4'hF, 5'd19, 32'hC0DE0009);
        ifc.stall = S_BUBBLE;
        tick();
        chk("t5.sreq_full", 64'(ifc.stall_req), 64'd1);
        tick();
        chk("t5.sreq_full2", 64'(ifc.stall_req), 64'd1);
        chk("t5.head_kept", 64'(ifc.debug_wb_pc), 64'h400);
        ifc.stall       = S_RUN;
        ifc.in_valid    = '0;
        ifc.trace_ready = 1'b1;
        for (int e = 0; e < 8; e++) begin
            chk_head($sformatf("t5.e%0d", e), 32'h400 + 32'(4*e), 4'hF, 5'(10 + e),
                     32'hC0DE0000 + 32'(e));
            chk($sformatf("t5.sreq_e%0d", e), 64'(ifc.stall_req), (e < 2) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t5.drained", 64'(ifc.trace_valid), 64'd0);

        // Reset with three entries queued and a bundle in flight
        ifc.trace_ready = 1'b0;
        set_lane(0, 1'b1, 32'h500, 1'b1, 4'hF, 5'd1, 32'h55550001);
        set_lane(1, 1'b1, 32'h504, 1'b1, 4'hF, 5'd2, 32'h55550002);
        tick();
        set_lane(1, 1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        set_lane(0, 1'b1, 32'h508, 1'b1, 4'hF, 5'd3, 32'h55550003);
        tick();
        set_lane(0, 1'b1, 32'h50C, 1'b1, 4'hF, 5'd4, 32'h55550004);
        set_lane(1, 1'b1, 32'h510, 1'b1, 4'hF, 5'd6, 32'h55550006);
        tick();
        chk_head("t1.pre", 32'h500, 4'hF, 5'd1, 32'h55550001);
        rst_n = 1'b0;
        tick();
        chk("t1.trace_valid", 64'(ifc.trace_valid), 64'd0);
        chk("t1.rf_we", 64'(ifc.rf_we), 64'd0);
        chk("t1.stall_req", 64'(ifc.stall_req), 64'd0);
        chk("t1.pc", 64'(ifc.debug_wb_pc), 64'd0);
        chk("t1.wen", 64'(ifc.debug_wb_rf_wen), 64'd0);
        chk("t1.wnum", 64'(ifc.debug_wb_rf_wnum), 64'd0);
        chk("t1.wdata", 64'(ifc.debug_wb_rf_wdata), 64'd0);
        rst_n        = 1'b1;
        ifc.in_valid = '0;
        tick();
        chk("t1.post_trace", 64'(ifc.trace_valid), 64'd0);
        chk("t1.post_we", 64'(ifc.rf_we), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
